// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and byte-enable patterns.
package mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mem_state_e;

   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   // Reserved size code is reported as misaligned so it can never reach the bus.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return addr_lo[0];
         SZ_WORD: return |addr_lo;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store-side byte enables and data replication,
// load-side lane extraction with sign or zero extension. Purely combinational.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_store_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   input  logic [1:0]  i_ld_size,
   input  logic [1:0]  i_ld_addr_lo,
   input  logic        i_ld_unsigned,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_load_data
);

   logic [31:0]        w_shifted;
   logic signed [7:0]  w_byte;
   logic signed [15:0] w_half;

   function automatic logic [31:0] extend_byte(input logic signed [7:0] b, input logic uns);
      return uns ? {24'h0, b} : {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] extend_half(input logic signed [15:0] h, input logic uns);
      return uns ? {16'h0, h} : {{16{h[15]}}, h};
   endfunction

   always_comb begin
      o_be    = BE_NONE;
      o_wdata = i_store_data;
      case (i_size)
         SZ_BYTE: begin
            o_be    = BE_BYTE0 << i_addr_lo;
            o_wdata = {4{i_store_data[7:0]}};
         end
         SZ_HALF: begin
            o_be    = i_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            o_wdata = {2{i_store_data[15:0]}};
         end
         SZ_WORD: o_be = BE_WORD;
         default: o_be = BE_NONE;
      endcase
   end

   // Bring the addressed lane down to bit 0 before extending.
   assign w_shifted = i_rdata >> {i_ld_addr_lo, 3'b000};
   assign w_byte    = w_shifted[7:0];
   assign w_half    = w_shifted[15:0];

   always_comb begin
      o_load_data = w_shifted;
      case (i_ld_size)
         SZ_BYTE: o_load_data = extend_byte(w_byte, i_ld_unsigned);
         SZ_HALF: o_load_data = extend_half(w_half, i_ld_unsigned);
         default: o_load_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: req/ack data-memory master with stall and fault.
// Optional stall-cycle counter enabled by defining MEM_PERF_CNT_EN.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead_in,
   input  logic              MemWrite_in,
   input  logic              RegWrite_in,
   input  logic              MemtoReg_in,
   input  logic [1:0]        mem_size_in,
   input  logic              mem_unsigned_in,
   input  logic [ADDR_W-1:0] alu_result_in,
   input  logic [31:0]       write_data_in,
   input  logic [4:0]        write_reg_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack,
   output logic              stall_out,
   output logic              RegWrite_out,
   output logic              MemtoReg_out,
   output logic [31:0]       mem_read_data_out,
   output logic [ADDR_W-1:0] alu_result_out,
   output logic [4:0]        write_reg_out,
   output logic              mem_fault_out,
   output logic [31:0]       stall_cycles_out
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   mem_state_e        r_state, w_next;
   logic              r_req, r_we, r_fault, r_read;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_be;
   logic [31:0]       r_wdata, r_rdata;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_ld_size, r_ld_lo;
   logic              r_ld_uns;

   logic              w_memop, w_misalign, w_issue, w_we, w_timeout;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata, w_load;

   // A simultaneous read+write request is treated as a read.
   assign w_memop    = MemRead_in | MemWrite_in;
   assign w_we       = MemWrite_in & ~MemRead_in;
   assign w_misalign = is_misaligned(mem_size_in, alu_result_in[1:0]);
   assign w_issue    = w_memop & ~w_misalign;
   assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   mem_lane_align u_align (
      .i_size        (mem_size_in),
      .i_addr_lo     (alu_result_in[1:0]),
      .i_store_data  (write_data_in),
      .o_be          (w_be),
      .o_wdata       (w_wdata),
      .i_ld_size     (r_ld_size),
      .i_ld_addr_lo  (r_ld_lo),
      .i_ld_unsigned (r_ld_uns),
      .i_rdata       (r_rdata),
      .o_load_data   (w_load)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_issue) w_next = BUSY;
         BUSY:    if (dmem_ack || w_timeout) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Bus registers are loaded at issue and held untouched for the whole BUSY phase.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_req     <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_be      <= BE_NONE;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_cnt     <= '0;
         r_fault   <= 1'b0;
         r_read    <= 1'b0;
         r_ld_size <= 2'b00;
         r_ld_lo   <= 2'b00;
         r_ld_uns  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_req     <= 1'b1;
                  r_we      <= w_we;
                  r_addr    <= {alu_result_in[ADDR_W-1:2], 2'b00};
                  r_be      <= w_be;
                  r_wdata   <= w_wdata;
                  r_cnt     <= '0;
                  r_read    <= ~w_we;
                  r_ld_size <= mem_size_in;
                  r_ld_lo   <= alu_result_in[1:0];
                  r_ld_uns  <= mem_unsigned_in;
               end
            end
            BUSY: begin
               if (dmem_ack) begin
                  r_rdata <= dmem_rdata;
                  r_req   <= 1'b0;
               end else if (w_timeout) begin
                  r_req   <= 1'b0;
                  r_fault <= 1'b1;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            DONE:    r_fault <= 1'b0;
            default: r_fault <= 1'b0;
         endcase
      end
   end

   // RegWrite is suppressed while stalled so the writeback happens once, in DONE.
   always_comb begin
      stall_out         = 1'b0;
      RegWrite_out      = 1'b0;
      mem_fault_out     = 1'b0;
      mem_read_data_out = '0;
      case (r_state)
         IDLE: begin
            stall_out     = w_issue;
            RegWrite_out  = RegWrite_in & ~w_memop;
            mem_fault_out = w_memop & w_misalign;
         end
         BUSY: stall_out = 1'b1;
         DONE: begin
            RegWrite_out      = RegWrite_in & ~r_fault;
            mem_fault_out     = r_fault;
            mem_read_data_out = (r_read && !r_fault) ? w_load : 32'h0;
         end
         default: stall_out = 1'b0;
      endcase
   end

   assign MemtoReg_out   = MemtoReg_in;
   assign alu_result_out = alu_result_in;
   assign write_reg_out  = write_reg_in;
   assign dmem_req       = r_req;
   assign dmem_we        = r_we;
   assign dmem_addr      = r_addr;
   assign dmem_be        = r_be;
   assign dmem_wdata     = r_wdata;

`ifdef MEM_PERF_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         r_stall_cnt <= '0;
      else if (stall_out) r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cycles_out = r_stall_cnt;
`else
   assign stall_cycles_out = '0;
`endif

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline.
- Sits between the EX/MEM buffer and MEM_WB_Buffer.
- Drives a req/ack data-memory bus, handles byte/half/word lane alignment and load sign-extension, and stalls the pipeline while an access is outstanding.
- Its outputs feed MEM_WB_Buffer directly.

Parameters:
- TIMEOUT_CYCLES, 16: ack wait limit; counted from the first BUSY cycle; must be ≥1.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- MemRead_in, MemWrite_in  in  1 each  from EX/MEM.
- RegWrite_in, MemtoReg_in  in  1 each  WB control from EX/MEM.
- mem_size_in  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as misaligned.
- mem_unsigned_in  in  1  1 = zero-extend loads.
- alu_result_in  in  ADDR_W  effective address / ALU result.
- write_data_in  in  32  store data, right-justified.
- write_reg_in  in  5  destination register.
- dmem_req  out  1  registered request, held until ack.
- dmem_we  out  1  write enable.
- dmem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read data; valid with ack.
- dmem_ack  in  1  one-cycle completion.
- stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- RegWrite_out, MemtoReg_out  out  1 each  to MEM_WB_Buffer.
- mem_read_data_out  out  32  formatted load data.
- alu_result_out  out  ADDR_W  pass-through.
- write_reg_out  out  5  pass-through.
- mem_fault_out  out  1  misalign or bus timeout.
- stall_cycles_out  out  32  see Optional Feature.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset: state IDLE; dmem_req/dmem_we 0; dmem_addr/dmem_be/dmem_wdata 0; read register 0; timeout counter 0; fault flag 0.
- memop = MemRead_in | MemWrite_in. If both are set, treat as a read.
- Alignment rule: half needs addr[0]=0; word needs addr[1:0]=00.
- IDLE, no memop:
  - stall_out=0.
  - Control, alu_result and write_reg pass through combinationally.
  - mem_read_data_out = 0.
- IDLE, memop misaligned:
  - No request; stall_out=0.
  - mem_fault_out=1 (combinational).
  - RegWrite_out forced 0.
- IDLE, memop aligned:
  - stall_out=1.
  - Next edge: go to BUSY; register dmem_req=1, dmem_we, dmem_addr, dmem_be, dmem_wdata.
  - Timeout counter cleared.
- Lanes are little-endian.
  - Byte: be = 1<<addr[1:0]; wdata = byte ×4.
  - Half: be = 0011 if addr[1]=0, else 1100; wdata = half ×2.
  - Word: be = 1111.
- BUSY:
  - stall_out=1; bus outputs held stable.
  - dmem_ack=1: capture dmem_rdata, drop dmem_req, go to DONE.
  - Counter reaches TIMEOUT_CYCLES without ack: drop dmem_req, set fault flag, go to DONE.
- DONE (exactly one cycle):
  - stall_out=0.
  - mem_read_data_out = captured lane, shifted to bit 0, then sign- or zero-extended.
  - On fault: mem_fault_out=1, RegWrite_out=0, read data 0.
  - Next edge: go to IDLE and clear the fault flag.
- Minimum memop latency: 3 cycles (IDLE, BUSY with ack, DONE). Each extra wait cycle adds 1.
- dmem_ack while in IDLE or DONE is ignored.
- Reset asserted mid-BUSY: immediate return to IDLE with dmem_req=0. The memory must drop the abandoned transaction.
- Back-to-back memops: the next one is evaluated in the IDLE cycle that follows DONE.

Optional Feature:
- Macro MEM_PERF_CNT_EN.
- Defined: stall_cycles_out is a 32-bit counter that increments every cycle stall_out=1. It wraps 0xFFFFFFFF→0 and is reset to 0.
- Undefined: stall_cycles_out tied to 0 and no counter logic.

Decomposition:
- Package mem_pkg:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - State enum IDLE/BUSY/DONE.
  - BE constants.
- Sub-module mem_lane_align (combinational), holding:
  - store lane replication and be generation;
  - load lane extraction and extension.
- FSM, counters and bus registers remain in mem_access_stage.

Test Plan:
- LW at 0x100, ack after 2 BUSY cycles, rdata 0xDEADBEEF → stall high 3 cycles; DONE outputs 0xDEADBEEF with RegWrite_out=1.
- LB at 0x103, rdata 0x80FF0000 → be=1000 during BUSY; read 0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH 0x1234ABCD at 0x202 → dmem_addr 0x200, be=1100, wdata 0xABCDABCD, we=1.
- LW at 0x101 → no dmem_req; mem_fault_out=1; RegWrite_out=0; stall_out=0.
- LW with no ack, TIMEOUT_CYCLES=4 → req drops after 4 BUSY cycles; DONE cycle has fault=1 and RegWrite_out=0; FSM back in IDLE.
- Reset pulled low mid-BUSY, then stray ack after release → dmem_req 0 immediately; IDLE; ack ignored; with MEM_PERF_CNT_EN, counter reads 0.
